// File: rtl/temp_average_controller.sv
// Averages a block of 64 unsigned temperature samples: accumulate, divide by 64, report.
// DivideBy64 is the combinational shifter stage that the controller sequences.
module temp_average_controller #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter bit          CONTINUOUS   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [31:0]             avg,
  output logic                    avg_valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t      state;
  logic [31:0] acc;
  logic [5:0]  cnt;
  logic [31:0] quot;
  logic [31:0] sample_ext;
  logic        accept;

  assign sample_ext = {{(32-SAMPLE_WIDTH){1'b0}}, sample};
  assign accept     = sample_valid && sample_ready;

  DivideBy64 u_div (
    .dividend (acc),
    .quotient (quot)
  );

  // Outputs are registered from the state being entered, so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      avg          <= '0;
      sample_ready <= 1'b0;
      avg_valid    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_valid && busy && !sample_ready)
        overrun <= 1'b1;
      if (abort) begin
        state        <= IDLE;
        acc          <= '0;
        cnt          <= '0;
        sample_ready <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= ACCUM;
              acc          <= '0;
              cnt          <= '0;
              overrun      <= 1'b0;
              sample_ready <= 1'b1;
              busy         <= 1'b1;
            end
          end
          ACCUM: begin
            if (accept) begin
              acc <= acc + sample_ext;
              cnt <= cnt + 6'd1;
              if (cnt == 6'd63) begin
                state        <= DIVIDE;
                sample_ready <= 1'b0;
              end
            end
          end
          DIVIDE: begin
            avg       <= quot;
            avg_valid <= 1'b1;
            state     <= DONE;
          end
          DONE: begin
            if (CONTINUOUS) begin
              state        <= ACCUM;
              acc          <= '0;
              cnt          <= '0;
              sample_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state        <= IDLE;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

module DivideBy64 (
  input  logic [31:0] dividend,
  output logic [31:0] quotient
);
  assign quotient = {6'b0, dividend[31:6]};
endmodule

// File: tb/tb_temp_average_controller.sv
// Directed bench for temp_average_controller: one-shot instance plus a CONTINUOUS instance.
module tb_temp_average_controller;

  logic        clk;
  logic        rst;
  logic        start, abort, sample_valid;
  logic [15:0] sample;
  logic        sample_ready, avg_valid, busy, overrun;
  logic [31:0] avg;

  logic        start2, abort2, sample_valid2;
  logic [15:0] sample2;
  logic        sample_ready2, avg_valid2, busy2, overrun2;
  logic [31:0] avg2;

  int checks;
  int failures;

  temp_average_controller #(.SAMPLE_WIDTH(16), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .avg(avg),
    .avg_valid(avg_valid), .busy(busy), .overrun(overrun)
  );

  temp_average_controller #(.SAMPLE_WIDTH(16), .CONTINUOUS(1'b1)) dut_cont (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .sample(sample2),
    .sample_valid(sample_valid2), .sample_ready(sample_ready2), .avg(avg2),
    .avg_valid(avg_valid2), .busy(busy2), .overrun(overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: called at a negedge, return at a later negedge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] v);
    sample = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send_n(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_sample(v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 0; abort = 0; sample_valid = 0; sample = '0;
    start2 = 0; abort2 = 0; sample_valid2 = 0; sample2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (avg !== 32'd0) begin failures++; $display("FAIL reset_avg got=%0d exp=0", avg); end
    checks++; if ({sample_ready, avg_valid, busy, overrun} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {sample_ready, avg_valid, busy, overrun}); end
  endtask

  task automatic test_basic();
    do_start();
    checks++; if ({busy, sample_ready} !== 2'b11) begin
      failures++; $display("FAIL basic_accum_flags got=%b exp=11", {busy, sample_ready}); end
    send_n(16'd100, 64);
    checks++; if ({avg_valid, sample_ready, busy} !== 3'b001 || avg !== 32'd0) begin
      failures++; $display("FAIL basic_divide_cycle got=%b avg=%0d exp=001 avg=0", {avg_valid, sample_ready, busy}, avg); end
    @(negedge clk);
    checks++; if (avg !== 32'd100 || avg_valid !== 1'b1) begin
      failures++; $display("FAIL basic_avg got=%0d/%b exp=100/1", avg, avg_valid); end
    @(negedge clk);
    checks++; if ({avg_valid, busy, overrun} !== 3'b000) begin
      failures++; $display("FAIL basic_after got=%b exp=000", {avg_valid, busy, overrun}); end
  endtask

  task automatic test_ramp();
    do_start();
    for (int i = 0; i < 64; i++) send_sample(16'(i));
    @(negedge clk);
    checks++; if (avg !== 32'd31 || avg_valid !== 1'b1) begin
      failures++; $display("FAIL ramp_avg got=%0d/%b exp=31/1", avg, avg_valid); end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    do_start();
    send_sample(16'd127);
    send_n(16'd0, 63);
    @(negedge clk);
    checks++; if (avg !== 32'd1 || avg_valid !== 1'b1) begin
      failures++; $display("FAIL single127_avg got=%0d/%b exp=1/1", avg, avg_valid); end
    @(negedge clk);
    do_start();
    send_n(16'hFFFF, 64);
    @(negedge clk);
    checks++; if (avg !== 32'd65535 || avg_valid !== 1'b1) begin
      failures++; $display("FAIL max_avg got=%0d/%b exp=65535/1", avg, avg_valid); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    do_start();
    send_n(16'd9, 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if ({busy, sample_ready, avg_valid} !== 3'b000 || avg !== 32'd65535) begin
      failures++; $display("FAIL abort_accum got=%b avg=%0d exp=000 avg=65535", {busy, sample_ready, avg_valid}, avg); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_abort_idle busy=%b exp=0", busy); end
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    checks++; if ({overrun, busy} !== 2'b00) begin
      failures++; $display("FAIL idle_valid got=%b exp=00", {overrun, busy}); end
    do_start();
    send_n(16'd5, 64);
    @(negedge clk);
    checks++; if (avg !== 32'd5 || avg_valid !== 1'b1) begin
      failures++; $display("FAIL abort_rerun_avg got=%0d/%b exp=5/1", avg, avg_valid); end
    @(negedge clk);
    do_start();
    send_n(16'd3, 64);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (avg !== 32'd5 || {avg_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL abort_divide got=%0d/%b exp=5/00", avg, {avg_valid, busy}); end
    @(negedge clk);
    checks++; if (avg !== 32'd5 || avg_valid !== 1'b0) begin
      failures++; $display("FAIL abort_divide_hold got=%0d/%b exp=5/0", avg, avg_valid); end
  endtask

  task automatic test_reset_mid();
    do_start();
    send_n(16'd7, 30);
    #2 rst = 1'b1;
    #1;
    checks++; if (avg !== 32'd0 || {sample_ready, avg_valid, busy, overrun} !== 4'b0000) begin
      failures++; $display("FAIL async_reset got=%0d/%b exp=0/0000", avg, {sample_ready, avg_valid, busy, overrun}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    send_n(16'd7, 64);
    @(negedge clk);
    checks++; if (avg !== 32'd7 || avg_valid !== 1'b1) begin
      failures++; $display("FAIL reset_rerun_avg got=%0d/%b exp=7/1", avg, avg_valid); end
    @(negedge clk);
  endtask

  task automatic test_continuous();
    int pulses;
    int ready_low;
    start2 = 1'b1; sample2 = 16'd20; sample_valid2 = 1'b1;
    pulses = 0; ready_low = 0;
    for (int k = 1; k <= 198; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (!sample_ready2) ready_low++;
      if (k == 65) begin
        checks++; if (overrun2 !== 1'b0) begin failures++; $display("FAIL cont_overrun_early got=%b exp=0", overrun2); end
      end
      if (avg_valid2) begin
        pulses++;
        checks++; if (k != 66 * pulses || avg2 !== 32'd20) begin
          failures++; $display("FAIL cont_pulse cycle=%0d avg=%0d exp cycle=%0d avg=20", k, avg2, 66 * pulses); end
      end
      if (k % 66 == 0) begin
        checks++; if (ready_low != 2) begin failures++; $display("FAIL cont_ready_low got=%0d exp=2", ready_low); end
        checks++; if (overrun2 !== 1'b1) begin failures++; $display("FAIL cont_overrun got=%b exp=1", overrun2); end
        ready_low = 0;
      end
    end
    checks++; if (pulses != 3) begin failures++; $display("FAIL cont_pulse_count got=%0d exp=3", pulses); end
    sample_valid2 = 1'b0; abort2 = 1'b1;
    @(negedge clk);
    abort2 = 1'b0;
    checks++; if ({busy2, sample_ready2} !== 2'b00) begin
      failures++; $display("FAIL cont_abort got=%b exp=00", {busy2, sample_ready2}); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_ramp();
    test_extremes();
    test_abort();
    test_reset_mid();
    test_continuous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
